// File: rtl/sid_audio_i2s.sv
// SID audio output: box-car decimator, one-entry holding buffer, mono I2S (Philips) transmitter.
// Latency: o_sample_valid 1 clk after the last contributing phi1 tick; a held sample goes out from the next frame start.
// Backpressure: none; a held sample overwritten before a frame start is dropped and flagged in sticky o_overrun.
module sid_audio_i2s #(
  parameter int DECIM_LOG2 = 5,
  parameter int BCLK_HALF  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_1mhz_ph1_en,
  input  logic [15:0] i_wave,
  input  logic        i_overrun_clr,
  output logic [15:0] o_sample,
  output logic        o_sample_valid,
  output logic        o_overrun,
  output logic        o_i2s_bclk,
  output logic        o_i2s_lrclk,
  output logic        o_i2s_sdata
);

  localparam int AW = 16 + DECIM_LOG2;
  localparam int DW = $clog2(BCLK_HALF);

  // Decimator state
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   sum;
  logic [DECIM_LOG2-1:0]  cnt;

  // Holding buffer and frame word
  logic [15:0] hold;
  logic        hold_full;
  logic [15:0] frame_w;

  // I2S timing
  logic [DW-1:0] div;
  logic          bclk_tick;
  logic          bclk_fall;
  logic          bclk;
  logic [4:0]    slot;
  logic [4:0]    slot_nxt;
  logic [3:0]    bit_idx;
  logic          frame_start;
  logic          lrclk;
  logic          sdata;

  // The accumulator is wide enough for 2^DECIM_LOG2 full-scale samples, so it never overflows.
  assign sum = acc + {{DECIM_LOG2{i_wave[15]}}, i_wave};

  // Accumulate phi1 samples; on the last tick of a block emit the mean and restart.
  // The top 16 bits of the sum are exactly sum >>> DECIM_LOG2 (floor division).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc            <= '0;
      cnt            <= '0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
    end else begin
      o_sample_valid <= 1'b0;
      if (clk_1mhz_ph1_en) begin
        if (cnt == '1) begin
          o_sample       <= sum[AW-1:DECIM_LOG2];
          o_sample_valid <= 1'b1;
          acc            <= '0;
          cnt            <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bclk_tick   = (div == DW'(BCLK_HALF - 1));
  assign bclk_fall   = bclk_tick & bclk;
  assign slot_nxt    = slot + 5'd1;
  assign frame_start = bclk_fall && (slot == 5'd31);
  // Slot s carries W[(16 - s) mod 16]: slots 1-16 give W[15:0], 17-31 give W[15:1],
  // and slot 0 gives W[0] of the word still in place at the frame-start edge.
  assign bit_idx     = 4'd0 - slot_nxt[3:0];

  // Free-running bit clock divider; BCLK starts low and first rises BCLK_HALF clk after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      bclk <= 1'b0;
    end else begin
      div  <= bclk_tick ? '0 : div + 1'b1;
      bclk <= bclk ^ bclk_tick;
    end
  end

  // Advance the slot and launch lrclk/sdata on BCLK falling edges only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot  <= '0;
      lrclk <= 1'b0;
      sdata <= 1'b0;
    end else if (bclk_fall) begin
      slot  <= slot_nxt;
      lrclk <= slot_nxt[4];
      sdata <= frame_w[bit_idx];
    end
  end

  // Holding buffer: frame start drains it first, a same-clk new sample then refills it without overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
      frame_w   <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (frame_start && hold_full) begin
        frame_w <= hold;
      end
      if (o_sample_valid) begin
        hold      <= o_sample;
        hold_full <= 1'b1;
      end else if (frame_start) begin
        hold_full <= 1'b0;
      end
      // Setting the sticky flag wins over a simultaneous clear.
      if (o_sample_valid && hold_full && !frame_start) begin
        o_overrun <= 1'b1;
      end else if (i_overrun_clr) begin
        o_overrun <= 1'b0;
      end
    end
  end

  assign o_i2s_bclk  = bclk;
  assign o_i2s_lrclk = lrclk;
  assign o_i2s_sdata = sdata;

endmodule

// File: tb/tb_sid_audio_i2s.sv
// Directed bench for sid_audio_i2s with DECIM_LOG2=2, BCLK_HALF=2 (frame = 128 clk).
// Checks decimation arithmetic, overrun flag, I2S frame contents and timing, and async reset.
module tb_sid_audio_i2s;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] wave;
  logic        ovr_clr;
  logic [15:0] o_sample;
  logic        o_sample_valid;
  logic        o_overrun;
  logic        o_i2s_bclk;
  logic        o_i2s_lrclk;
  logic        o_i2s_sdata;

  int total = 0;
  int bad   = 0;

  logic chk_en = 1'b0;
  logic bclk_q = 1'b0;
  logic lr_q   = 1'b0;
  logic sd_q   = 1'b0;

  sid_audio_i2s #(.DECIM_LOG2(2), .BCLK_HALF(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clk_1mhz_ph1_en (en),
    .i_wave          (wave),
    .i_overrun_clr   (ovr_clr),
    .o_sample        (o_sample),
    .o_sample_valid  (o_sample_valid),
    .o_overrun       (o_overrun),
    .o_i2s_bclk      (o_i2s_bclk),
    .o_i2s_lrclk     (o_i2s_lrclk),
    .o_i2s_sdata     (o_i2s_sdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // lrclk/sdata may only change together with a BCLK falling edge.
  always @(negedge clk) begin
    if (chk_en && ((o_i2s_lrclk !== lr_q) || (o_i2s_sdata !== sd_q)))
      check("edge_align", {30'd0, bclk_q, o_i2s_bclk}, 32'd2);
    bclk_q = o_i2s_bclk;
    lr_q   = o_i2s_lrclk;
    sd_q   = o_i2s_sdata;
  end

  task automatic tick(input logic [15:0] v);
    @(negedge clk);
    en   = 1'b1;
    wave = v;
    @(negedge clk);
    en   = 1'b0;
    wave = 16'h0;
  endtask

  task automatic decim4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    tick(a);
    tick(b);
    tick(c);
    tick(d);
  endtask

  task automatic wait_bclk_rise();
    logic prev;
    logic found;
    prev  = o_i2s_bclk;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!prev && o_i2s_bclk) begin
        found = 1'b1;
        break;
      end
      prev = o_i2s_bclk;
    end
    if (!found) check("bclk_rise_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_lr_fall();
    logic prev;
    logic found;
    prev  = o_i2s_lrclk;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (prev && !o_i2s_lrclk) begin
        found = 1'b1;
        break;
      end
      prev = o_i2s_lrclk;
    end
    if (!found) check("frame_start_timeout", {31'd0, found}, 32'd1);
  endtask

  // Sample sdata/lrclk at 32 consecutive BCLK rises; bit 31 is slot 0.
  task automatic capture_slots(output logic [31:0] sd, output logic [31:0] lr);
    sd = '0;
    lr = '0;
    for (int k = 0; k < 32; k++) begin
      wait_bclk_rise();
      sd[31-k] = o_i2s_sdata;
      lr[31-k] = o_i2s_lrclk;
    end
  endtask

  logic [31:0] sd;
  logic [31:0] lr;
  logic [15:0] w;
  logic        found;

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    wave    = 16'h0;
    ovr_clr = 1'b0;
    #23;
    check("rst_sample", {16'd0, o_sample}, 32'd0);
    check("rst_valid",  {31'd0, o_sample_valid}, 32'd0);
    check("rst_overrun", {31'd0, o_overrun}, 32'd0);
    check("rst_bclk",   {31'd0, o_i2s_bclk}, 32'd0);
    check("rst_lrclk",  {31'd0, o_i2s_lrclk}, 32'd0);
    check("rst_sdata",  {31'd0, o_i2s_sdata}, 32'd0);

    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("bclk_low_1st", {31'd0, o_i2s_bclk}, 32'd0);
    @(negedge clk);
    check("bclk_rise_2nd", {31'd0, o_i2s_bclk}, 32'd1);

    // Decimation arithmetic: mean of 4, floor rounding, full-scale extremes.
    decim4(16'd100, 16'd200, 16'd300, 16'd400);
    check("dec_valid", {31'd0, o_sample_valid}, 32'd1);
    check("dec_mean", {16'd0, o_sample}, 32'd250);
    @(negedge clk);
    check("dec_valid_pulse", {31'd0, o_sample_valid}, 32'd0);

    decim4(16'hFFFF, 16'h0, 16'h0, 16'h0);
    check("dec_floor_m1", {16'd0, o_sample}, 32'h0000FFFF);

    decim4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    check("dec_negfull", {16'd0, o_sample}, 32'h00008000);

    decim4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    check("dec_posfull", {16'd0, o_sample}, 32'h00007FFF);

    decim4(16'hFFFB, 16'h0, 16'h0, 16'h0);
    check("dec_floor_m5", {16'd0, o_sample}, 32'h0000FFFE);

    // Several samples before the first frame start: overrun is sticky until cleared.
    @(negedge clk);
    check("ovr_set_early", {31'd0, o_overrun}, 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_clr", {31'd0, o_overrun}, 32'd0);

    // Drain the holding buffer (loads 0xFFFE), then send 0xA5C3.
    wait_lr_fall();
    w = 16'hA5C3;
    decim4(w, w, w, w);
    check("a5c3_sample", {16'd0, o_sample}, {16'd0, w});
    @(negedge clk);
    @(negedge clk);
    check("a5c3_no_ovr", {31'd0, o_overrun}, 32'd0);
    wait_lr_fall();
    capture_slots(sd, lr);
    check("f1_sdata", sd, {1'b0, w, w[15:1]});
    check("f1_lrclk", lr, 32'h0000FFFF);
    // No new samples: the same word repeats, slot 0 carries its own W[0].
    wait_lr_fall();
    capture_slots(sd, lr);
    check("f2_repeat", sd, {1'b1, w, w[15:1]});
    wait_lr_fall();
    capture_slots(sd, lr);
    check("f3_repeat", sd, {1'b1, w, w[15:1]});
    check("f3_lrclk", lr, 32'h0000FFFF);

    // Two samples within one frame: overrun, and the second one is transmitted.
    wait_lr_fall();
    decim4(16'h1111, 16'h1111, 16'h1111, 16'h1111);
    @(negedge clk);
    check("ovr_first_ok", {31'd0, o_overrun}, 32'd0);
    decim4(16'h2222, 16'h2222, 16'h2222, 16'h2222);
    @(negedge clk);
    check("ovr_second", {31'd0, o_overrun}, 32'd1);
    w = 16'h2222;
    wait_lr_fall();
    capture_slots(sd, lr);
    check("ovr_tx_second", sd, {1'b1, w, w[15:1]});
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_clr2", {31'd0, o_overrun}, 32'd0);

    // Clear in the same clk as a new overrun: set wins.
    wait_lr_fall();
    decim4(16'h4444, 16'h4444, 16'h4444, 16'h4444);
    decim4(16'h5555, 16'h5555, 16'h5555, 16'h5555);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_set_wins", {31'd0, o_overrun}, 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_clr3", {31'd0, o_overrun}, 32'd0);

    // Async reset mid-frame while bclk, lrclk and sdata are all high (W = 0x5555, right half).
    wait_lr_fall();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_i2s_bclk && o_i2s_lrclk && o_i2s_sdata) begin
        found = 1'b1;
        break;
      end
    end
    check("pre_rst_all_high", {31'd0, found}, 32'd1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_bclk",  {31'd0, o_i2s_bclk}, 32'd0);
    check("arst_lrclk", {31'd0, o_i2s_lrclk}, 32'd0);
    check("arst_sdata", {31'd0, o_i2s_sdata}, 32'd0);
    check("arst_sample", {16'd0, o_sample}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    // The frame restarts at slot 0 on release and carries W = 0.
    capture_slots(sd, lr);
    check("post_rst_sdata", sd, 32'h0);
    check("post_rst_lrclk", lr, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
